// File: rtl/aes_128_inv_pkg.sv
// aes_128_inv_pkg: shared types, S-box tables, GF(2^8) helpers and key schedule for the AES-128 inverse cipher
package aes_128_inv_pkg;
  typedef logic [3:0][3:0][7:0] state_t;
  typedef logic [10:0][3:0][3:0][7:0] rks_t;
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, CHECK, DONE} fsm_t;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  // Multiply by a 4-bit constant; InvMixColumns only needs 9, 11, 13 and 14.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      p = m[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  // Cyclic rotation of the state n columns to the left.
  function automatic state_t rotl(input state_t s, input int n);
    state_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[r][c] = s[r][2'(c + n)];
    return o;
  endfunction
  // Full key schedule; entry i is the round key for round i, laid out like the state.
  function automatic rks_t key_expand(input state_t k);
    rks_t o;
    logic [3:0][7:0] t;
    logic [7:0] rc;
    o[0] = k;
    rc = 8'h01;
    for (int i = 1; i <= 10; i++) begin
      for (int r = 0; r < 4; r++)
        t[r] = SBOX[o[i-1][2'(r + 1)][3]];
      t[0] = t[0] ^ rc;
      for (int r = 0; r < 4; r++) begin
        o[i][r][0] = o[i-1][r][0] ^ t[r];
        for (int c = 1; c < 4; c++)
          o[i][r][c] = o[i-1][r][c] ^ o[i][r][c-1];
      end
      rc = xtime(rc);
    end
    return o;
  endfunction
endpackage

// File: rtl/aes_128_inv_round.sv
// aes_128_inv_round: one combinational AES inverse round
// state/round_key: input block and round key; last_round: skip InvMixColumns; result: round output
module aes_128_inv_round
  import aes_128_inv_pkg::*;
(
  input  state_t state,
  input  state_t round_key,
  input  logic   last_round,
  output state_t result
);
  state_t s, m;
  always_comb begin
    s = '0;
    m = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = INV_SBOX[state[r][2'(c - r)]] ^ round_key[r][c];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = gmul(s[r][c], 4'd14) ^ gmul(s[2'(r + 1)][c], 4'd11) ^
                  gmul(s[2'(r + 2)][c], 4'd13) ^ gmul(s[2'(r + 3)][c], 4'd9);
  end
  assign result = last_round ? s : m;
endmodule

// File: rtl/aes_128_inv.sv
// aes_128_inv: iterative AES-128 decryption with optional time-redundant error detection
// clock/reset(active-low async); start, ciphertext, key, ced_en, fault_*: request inputs latched on accept;
// plaintext, busy, done, fault_detected: results and status
module aes_128_inv
  import aes_128_inv_pkg::*;
#(
  parameter int ROUNDS = 10,
  parameter int ROT    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  state_t     ciphertext,
  input  state_t     key,
  input  logic       ced_en,
  output state_t     plaintext,
  output logic       busy,
  output logic       done,
  output logic       fault_detected,
  input  logic       fault_en,
  input  logic [3:0] fault_round,
  input  logic [3:0] fault_byte,
  input  logic [2:0] fault_bit
);
  fsm_t       fsm;
  state_t     st, shadow, ct_r, key_r, rk, r_raw, r, c_rot, c_back;
  rks_t       rks;
  logic [3:0] round, fr_r, fbyte_r;
  logic [2:0] fbit_r;
  logic       ced_r, fen_r, last;
  assign rks  = key_expand(key_r);
  assign rk   = rks[round];
  assign last = round == 4'd0;
  aes_128_inv_round u_primary (.state(st), .round_key(rk), .last_round(last), .result(r_raw));
  // The whole round commutes with a column rotation, so the rotated recompute must match after rotating back.
  aes_128_inv_round u_check (.state(rotl(st, ROT)), .round_key(rotl(rk, ROT)), .last_round(last), .result(c_rot));
  assign c_back = rotl(c_rot, 4 - ROT);
  always_comb begin
    r = r_raw;
    if (fen_r && fr_r == round)
      r[fbyte_r[1:0]][fbyte_r[3:2]][fbit_r] = ~r_raw[fbyte_r[1:0]][fbyte_r[3:2]][fbit_r];
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm <= IDLE;
      st <= '0;
      shadow <= '0;
      ct_r <= '0;
      key_r <= '0;
      round <= '0;
      fr_r <= '0;
      fbyte_r <= '0;
      fbit_r <= '0;
      ced_r <= 1'b0;
      fen_r <= 1'b0;
      plaintext <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      fault_detected <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: if (start) begin
          fsm <= LOAD;
          busy <= 1'b1;
          fault_detected <= 1'b0;
          ct_r <= ciphertext;
          key_r <= key;
          ced_r <= ced_en;
          fen_r <= fault_en;
          fr_r <= fault_round;
          fbyte_r <= fault_byte;
          fbit_r <= fault_bit;
        end
        LOAD: begin
          st <= ct_r ^ rks[ROUNDS];
          round <= 4'(ROUNDS - 1);
          fsm <= ROUND;
        end
        ROUND: if (ced_r) begin
          shadow <= r;
          fsm <= CHECK;
        end else begin
          st <= r;
          round <= last ? round : round - 4'd1;
          fsm <= last ? DONE : ROUND;
        end
        CHECK: begin
          fault_detected <= fault_detected | (c_back != shadow);
          st <= shadow;
          round <= last ? round : round - 4'd1;
          fsm <= last ? DONE : ROUND;
        end
        DONE: begin
          plaintext <= st;
          done <= 1'b1;
          busy <= 1'b0;
          fsm <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_128_inv.sv
// tb_aes_128_inv: scoreboard bench for aes_128_inv using FIPS-197 vectors, CED and fault-injection scenarios
module tb_aes_128_inv;
  import aes_128_inv_pkg::*;
  typedef struct {
    state_t pt;
    bit     eq;
    bit     fd;
  } exp_t;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  state_t     ciphertext = '0;
  state_t     key = '0;
  logic       ced_en = 1'b0;
  state_t     plaintext;
  logic       busy, done, fault_detected;
  logic       fault_en = 1'b0;
  logic [3:0] fault_round = '0;
  logic [3:0] fault_byte = '0;
  logic [2:0] fault_bit = '0;
  exp_t       sb[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  int         cyc, fd_cyc, busy_bad;
  aes_128_inv dut (
    .clock(clock), .reset(reset), .start(start), .ciphertext(ciphertext), .key(key),
    .ced_en(ced_en), .plaintext(plaintext), .busy(busy), .done(done),
    .fault_detected(fault_detected), .fault_en(fault_en), .fault_round(fault_round),
    .fault_byte(fault_byte), .fault_bit(fault_bit)
  );
  always #5 clock = ~clock;
  function automatic state_t to_state(input logic [127:0] v);
    state_t s;
    for (int k = 0; k < 16; k++)
      s[k % 4][k / 4] = v[127 - 8 * k -: 8];
    return s;
  endfunction
  // Drives one request, records its expectation, then scrambles the inputs since they are latched on accept.
  task automatic launch(input logic [127:0] c, input logic [127:0] k, input logic ced, input logic fen,
                        input logic [3:0] fr, input logic [3:0] fb, input logic [2:0] fbit,
                        input logic [127:0] exp_pt, input bit eq, input bit efd);
    exp_t x;
    @(negedge clock);
    ciphertext = to_state(c);
    key = to_state(k);
    ced_en = ced;
    fault_en = fen;
    fault_round = fr;
    fault_byte = fb;
    fault_bit = fbit;
    start = 1'b1;
    x.pt = to_state(exp_pt);
    x.eq = eq;
    x.fd = efd;
    sb.push_back(x);
    @(posedge clock);
    #1;
    start = 1'b0;
    ciphertext = to_state({$urandom, $urandom, $urandom, $urandom});
    key = to_state({$urandom, $urandom, $urandom, $urandom});
    ced_en = ~ced;
    fault_en = ~fen;
    fault_round = 4'($urandom);
  endtask
  task automatic wait_done(output int n, output int fdc, output int bb);
    n = 0;
    fdc = -1;
    bb = 0;
    while (!done && n < 60) begin
      @(posedge clock);
      #1;
      n++;
      if (fault_detected && fdc < 0) fdc = n;
      if (!done && !busy) bb++;
    end
  endtask
  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (plaintext !== '0) begin errors++; $display("FAIL reset_pt got %h want 0", plaintext); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (fault_detected !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", fault_detected); end
    @(negedge clock);
    reset = 1'b1;
  endtask
  task automatic test_plain(input logic [127:0] c, input logic [127:0] k, input logic [127:0] p);
    launch(c, k, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, p, 1'b1, 1'b0);
    wait_done(cyc, fd_cyc, busy_bad);
    e = sb.pop_front();
    checks++; if (cyc !== 12) begin errors++; $display("FAIL plain_latency got %0d want 12", cyc); end
    checks++; if (plaintext !== e.pt) begin errors++; $display("FAIL plain_pt got %h want %h", plaintext, e.pt); end
    checks++; if (fault_detected !== e.fd) begin errors++; $display("FAIL plain_fd got %b want %b", fault_detected, e.fd); end
    checks++; if (busy_bad !== 0 || busy !== 1'b0) begin errors++; $display("FAIL plain_busy got gaps %0d busy %b want 0 0", busy_bad, busy); end
    @(posedge clock);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL plain_done_pulse got %b want 0", done); end
  endtask
  task automatic test_ced(input logic [127:0] c, input logic [127:0] k, input logic [127:0] p);
    launch(c, k, 1'b1, 1'b0, 4'd0, 4'd0, 3'd0, p, 1'b1, 1'b0);
    wait_done(cyc, fd_cyc, busy_bad);
    e = sb.pop_front();
    checks++; if (cyc !== 22) begin errors++; $display("FAIL ced_latency got %0d want 22", cyc); end
    checks++; if (plaintext !== e.pt) begin errors++; $display("FAIL ced_pt got %h want %h", plaintext, e.pt); end
    checks++; if (fd_cyc !== -1) begin errors++; $display("FAIL ced_fd got cycle %0d want never", fd_cyc); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL ced_busy got gaps %0d want 0", busy_bad); end
  endtask
  task automatic test_fault_ced;
    launch(C1_CT, C1_KEY, 1'b1, 1'b1, 4'd5, 4'd3, 3'd7, C1_PT, 1'b0, 1'b1);
    wait_done(cyc, fd_cyc, busy_bad);
    e = sb.pop_front();
    checks++; if (cyc !== 22) begin errors++; $display("FAIL fault_ced_latency got %0d want 22", cyc); end
    checks++; if (plaintext === e.pt) begin errors++; $display("FAIL fault_ced_pt got %h want not %h", plaintext, e.pt); end
    checks++; if (fault_detected !== e.fd) begin errors++; $display("FAIL fault_ced_fd got %b want %b", fault_detected, e.fd); end
    checks++; if (fd_cyc !== 11) begin errors++; $display("FAIL fault_ced_fd_cycle got %0d want 11", fd_cyc); end
    repeat (3) @(posedge clock);
    #1;
    checks++; if (fault_detected !== 1'b1) begin errors++; $display("FAIL fault_sticky got %b want 1", fault_detected); end
    launch(C1_CT, C1_KEY, 1'b1, 1'b0, 4'd5, 4'd3, 3'd7, C1_PT, 1'b1, 1'b0);
    checks++; if (fault_detected !== 1'b0) begin errors++; $display("FAIL fault_clear got %b want 0", fault_detected); end
    wait_done(cyc, fd_cyc, busy_bad);
    e = sb.pop_front();
    checks++; if (plaintext !== e.pt) begin errors++; $display("FAIL fault_recover_pt got %h want %h", plaintext, e.pt); end
    checks++; if (fd_cyc !== -1) begin errors++; $display("FAIL fault_recover_fd got cycle %0d want never", fd_cyc); end
  endtask
  task automatic test_fault_plain;
    launch(C1_CT, C1_KEY, 1'b0, 1'b1, 4'd5, 4'd3, 3'd7, C1_PT, 1'b0, 1'b0);
    wait_done(cyc, fd_cyc, busy_bad);
    e = sb.pop_front();
    checks++; if (cyc !== 12) begin errors++; $display("FAIL fault_plain_latency got %0d want 12", cyc); end
    checks++; if (plaintext === e.pt) begin errors++; $display("FAIL fault_plain_pt got %h want not %h", plaintext, e.pt); end
    checks++; if (fd_cyc !== -1) begin errors++; $display("FAIL fault_plain_fd got cycle %0d want never", fd_cyc); end
  endtask
  task automatic test_back_to_back;
    int ndone, dcyc;
    ndone = 0;
    dcyc = -1;
    launch(C1_CT, C1_KEY, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, C1_PT, 1'b1, 1'b0);
    ciphertext = to_state(B_CT);
    key = to_state(B_KEY);
    for (int i = 1; i <= 30; i++) begin
      @(posedge clock);
      #1;
      if (done) begin
        ndone++;
        dcyc = i;
      end
      start = (i == 4);
    end
    e = sb.pop_front();
    checks++; if (ndone !== 1) begin errors++; $display("FAIL b2b_done_count got %0d want 1", ndone); end
    checks++; if (dcyc !== 12) begin errors++; $display("FAIL b2b_done_cycle got %0d want 12", dcyc); end
    checks++; if (plaintext !== e.pt) begin errors++; $display("FAIL b2b_pt got %h want %h", plaintext, e.pt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
  endtask
  task automatic test_reset_abort;
    int ndone;
    ndone = 0;
    launch(C1_CT, C1_KEY, 1'b1, 1'b1, 4'd9, 4'd0, 3'd0, C1_PT, 1'b0, 1'b1);
    repeat (6) @(posedge clock);
    #1;
    checks++; if (fault_detected !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL abort_pre got fd %b busy %b want 1 1", fault_detected, busy); end
    reset = 1'b0;
    #1;
    checks++; if (plaintext !== '0) begin errors++; $display("FAIL abort_pt got %h want 0", plaintext); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_busy_done got %b %b want 0 0", busy, done); end
    checks++; if (fault_detected !== 1'b0) begin errors++; $display("FAIL abort_fd got %b want 0", fault_detected); end
    sb.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clock);
      #1;
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", ndone); end
    test_plain(C1_CT, C1_KEY, C1_PT);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset;
    test_plain(C1_CT, C1_KEY, C1_PT);
    test_ced(C1_CT, C1_KEY, C1_PT);
    test_ced(B_CT, B_KEY, B_PT);
    test_plain(B_CT, B_KEY, B_PT);
    test_fault_ced;
    test_fault_plain;
    test_back_to_back;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
